// File: rtl/ay_bus_pkg.sv
// Shared types and helpers for the AY-bus front end.
//   state_t     : access-cycle FSM states
//   cmd_t       : decoded AY bus command
//   CTRL_PREFIX : data[7:3] pattern marking a chip-select control write
//   phase_w()   : width of the shared phase down-counter
package ay_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_WAIT_REL
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE, CMD_WRADDR, CMD_WRDATA, CMD_RDDATA
  } cmd_t;

  localparam logic [4:0] CTRL_PREFIX = 5'b11111;

  function automatic int phase_w(input int s, input int p, input int h);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ay_bus_cycler_filter.sv
// ay_sig_filter: resynchroniser plus hysteresis filter for one async line.
//   clk, rst : clock, async active-high reset
//   din      : asynchronous input
//   q        : filtered output; flips only after FILT_LEN consecutive
//              synced samples that disagree with its current value
module ay_sig_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;   // consecutive samples disagreeing with q

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (sync[SYNC_STAGES-1] == q) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        q   <= sync[SYNC_STAGES-1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ay_bus_cycler.sv
// ay_bus_cycler: AY-bus front end for multi-YM2203 TurboFM boards.
// Filters the async AY controls, decodes WRADDR/WRDATA/RDDATA and runs one
// setup/strobe/hold YM access per accepted command. WRADDR of 0xF8..0xFF is
// a chip-select control write and runs no YM cycle.
//   clk, rst                   : clock, async active-high reset
//   aybc1, aybc2, aybdir       : async AY bus controls
//   aya8, aya9_n               : async chip address (8=1, 9_n=0 selects)
//   zd_in / zd_out / zd_oe     : Z80 data in, read data out, out enable
//   ym_d_out / ym_d_in / ym_d_oe : YM data bus
//   ym_cs_n, ym_wr_n, ym_rd_n, ym_a0 : YM control
//   chip_sel, busy             : selected chip, FSM not idle
module ay_bus_cycler
  import ay_bus_pkg::*;
#(
  parameter int NCHIPS      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 14,
  parameter int HOLD_CYC    = 2,
  localparam int CSW        = (NCHIPS > 1) ? $clog2(NCHIPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aybc1,
  input  logic              aybc2,
  input  logic              aybdir,
  input  logic              aya8,
  input  logic              aya9_n,
  input  logic [7:0]        zd_in,
  output logic [7:0]        zd_out,
  output logic              zd_oe,
  output logic [7:0]        ym_d_out,
  input  logic [7:0]        ym_d_in,
  output logic              ym_d_oe,
  output logic [NCHIPS-1:0] ym_cs_n,
  output logic              ym_wr_n,
  output logic              ym_rd_n,
  output logic              ym_a0,
  output logic [CSW-1:0]    chip_sel,
  output logic              busy
);

  localparam int PW = phase_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  // raw[0]=WRADDR, raw[1]=WRDATA, raw[2]=RDDATA
  logic [2:0] tup, raw, filt, filt_q, rise;
  logic       addr_hit;

  assign tup      = {aybdir, aybc2, aybc1};
  assign addr_hit = aya8 & ~aya9_n;
  assign raw[0]   = addr_hit & (tup == 3'b001 || tup == 3'b100 || tup == 3'b111);
  assign raw[1]   = addr_hit & (tup == 3'b110);
  assign raw[2]   = addr_hit & (tup == 3'b011);

  for (genvar i = 0; i < 3; i++) begin : g_filt
    ay_sig_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt (
      .clk(clk), .rst(rst), .din(raw[i]), .q(filt[i])
    );
  end

  assign rise  = filt & ~filt_q;
  assign zd_oe = filt[2];

  // zd_in gets the same resync depth as the controls, so it is stable by the
  // time the filtered command rises.
  logic [SYNC_STAGES-1:0][7:0] zd_sync;
  logic [7:0]                  zd_s;
  assign zd_s = zd_sync[SYNC_STAGES-1];

  state_t          state, state_n;
  cmd_t            cmd, cmd_n;
  logic [PW-1:0]   phase, phase_n;
  logic [7:0]      data, data_n;
  logic [CSW-1:0]  chip_sel_n;
  logic [2:0]      sel_raw;
  logic [NCHIPS-1:0] cs_n_n;
  logic            wr_n_n, rd_n_n, a0_n, doe_n;

  assign sel_raw  = ~zd_s[2:0];
  assign ym_d_out = data;

  always_comb begin
    state_n    = state;
    cmd_n      = cmd;
    phase_n    = phase;
    data_n     = data;
    chip_sel_n = chip_sel;
    case (state)
      ST_IDLE: if (|rise) begin
        data_n = zd_s;
        cmd_n  = rise[0] ? CMD_WRADDR : (rise[1] ? CMD_WRDATA : CMD_RDDATA);
        if (rise[0] && zd_s[7:3] == CTRL_PREFIX) begin
          if (int'(sel_raw) < NCHIPS) chip_sel_n = CSW'(sel_raw);
          state_n = ST_WAIT_REL;
        end else begin
          state_n = ST_SETUP;
          phase_n = PW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: if (phase == '0) begin
        state_n = ST_STROBE;
        phase_n = PW'(PULSE_CYC - 1);
      end else phase_n = phase - 1'b1;
      ST_STROBE: if (phase == '0) begin
        state_n = ST_HOLD;
        phase_n = PW'(HOLD_CYC - 1);
      end else phase_n = phase - 1'b1;
      ST_HOLD: if (phase == '0) state_n = ST_WAIT_REL;
               else phase_n = phase - 1'b1;
      ST_WAIT_REL: if (filt == '0) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // YM outputs are decoded from the next state and registered, so the
    // strobes and selects never glitch.
    cs_n_n = '1;
    wr_n_n = 1'b1;
    rd_n_n = 1'b1;
    a0_n   = 1'b0;
    doe_n  = 1'b0;
    if (state_n == ST_SETUP || state_n == ST_STROBE || state_n == ST_HOLD) begin
      cs_n_n[chip_sel_n] = 1'b0;
      a0_n  = (cmd_n != CMD_WRADDR);
      doe_n = (cmd_n != CMD_RDDATA);
      if (state_n == ST_STROBE) begin
        if (cmd_n == CMD_RDDATA) rd_n_n = 1'b0;
        else                     wr_n_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd      <= CMD_NONE;
      phase    <= '0;
      data     <= '0;
      chip_sel <= '0;
      filt_q   <= '0;
      zd_sync  <= '0;
      zd_out   <= '0;
      ym_cs_n  <= '1;
      ym_wr_n  <= 1'b1;
      ym_rd_n  <= 1'b1;
      ym_a0    <= 1'b0;
      ym_d_oe  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cmd      <= cmd_n;
      phase    <= phase_n;
      data     <= data_n;
      chip_sel <= chip_sel_n;
      filt_q   <= filt;
      zd_sync  <= {zd_sync[SYNC_STAGES-2:0], zd_in};
      // read data is taken on the edge that ends the strobe
      if (state == ST_STROBE && phase == '0 && cmd == CMD_RDDATA) zd_out <= ym_d_in;
      ym_cs_n  <= cs_n_n;
      ym_wr_n  <= wr_n_n;
      ym_rd_n  <= rd_n_n;
      ym_a0    <= a0_n;
      ym_d_oe  <= doe_n;
      busy     <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: doc/ay_bus_cycler.md
# ay_bus_cycler

Parametrised AY-bus front end for multi-YM2203 TurboFM designs. It synchronises and hysteresis-filters the asynchronous AY control lines, then decodes address-write, data-write and data-read commands. For each accepted command it forms one complete YM access cycle with programmable setup, strobe and hold widths. It also intercepts chip-select control writes, latches write data, and captures read data for the Z80 bus.

## Interface
- NCHIPS, 2, number of YM chips, 1..8
- SYNC_STAGES, 2, resync flop depth, ≥2
- FILT_LEN, 2, consecutive equal synced samples needed to change the filtered state, ≥1
- SETUP_CYC, 1, cycles from cs_n/a0 valid to strobe low, ≥1
- PULSE_CYC, 14, wr_n/rd_n low width in cycles, ≥1
- HOLD_CYC, 2, cycles from strobe high to cs_n high, ≥1

Ports:
- clk  in  1  system clock (56 MHz nominal)
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- aybc1, aybc2, aybdir  in  1  async AY bus controls
- aya8  in  1  async, active-high chip address
- aya9_n  in  1  async, active-low chip address
- zd_in  in  8  Z80 data bus input, async
- zd_out  out  8  read data toward the Z80
- zd_oe  out  1  drive zd_out while a filtered read is active
- ym_d_out  out  8  data toward the YMs
- ym_d_in  in  8  data from the YMs
- ym_d_oe  out  1  drive ym_d_out during write cycles
- ym_cs_n  out  NCHIPS  per-chip select, active low
- ym_wr_n, ym_rd_n  out  1  strobes, active low
- ym_a0  out  1  YM address line
- chip_sel  out  clog2(NCHIPS) or 1  currently selected chip
- busy  out  1  FSM not in IDLE

## Operation
- Command decode, with the raw tuple {aybdir,aybc2,aybc1}, aya8=1 and aya9_n=0:
  - WRADDR: 001, 100 or 111.
  - WRDATA: 110.
  - RDDATA: 011.
  - Anything else decodes to none.
  - The three commands are mutually exclusive by construction.
- Filtering:
  - Each command passes through an ay_sig_filter.
  - The output goes high after FILT_LEN consecutive synced 1s and low after FILT_LEN consecutive 0s.
  - Otherwise the output holds its value.
- FSM states: IDLE, SETUP, STROBE, HOLD, WAIT_REL.
- IDLE to SETUP happens on a filtered rising edge of any command.
  - zd_in is sampled into the data latch on that same edge.
  - The latched value comes from the resynced copy, taken SYNC_STAGES cycles late and stable by then.
- Control write: a WRADDR whose latched data has [7:3]=11111 is a control write.
  - chip_sel becomes ~data[2:0] if that value is less than NCHIPS; otherwise chip_sel is unchanged.
  - No YM cycle is run; the FSM goes directly to WAIT_REL.
- SETUP:
  - ym_cs_n[chip_sel] is driven low.
  - ym_a0 is 0 for WRADDR and 1 for WRDATA/RDDATA.
  - ym_d_oe is 1 for writes.
  - The state lasts SETUP_CYC cycles.
- STROBE:
  - ym_wr_n is low for writes; ym_rd_n is low for reads.
  - The state lasts PULSE_CYC cycles and always runs to completion, even if the command drops mid-strobe.
- Read capture: on the last STROBE cycle of a read, ym_d_in is captured into zd_out.
- HOLD:
  - Strobes are high.
  - cs_n, a0 and d_oe are held for HOLD_CYC cycles.
- WAIT_REL:
  - All YM outputs are inactive.
  - The FSM returns to IDLE once all filtered commands are low.
  - This guarantees exactly one cycle per assertion.
- zd_oe = filtered RDDATA (independent of FSM state), so the Z80 sees the last captured value.
- Reset values:
  - ym_cs_n all 1; ym_wr_n=1; ym_rd_n=1; ym_a0=0.
  - ym_d_oe=0; zd_oe=0; zd_out=0; ym_d_out=0.
  - chip_sel=0; busy=0; FSM=IDLE; filters low.
- Reset asserted mid-cycle forces all of these immediately (asynchronously).

## Timing
- Phase counter is one down-counter, width clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1), reloaded on each state entry.
- Latency: after a clean async rising edge, the filtered command goes high at rising edge SYNC_STAGES+FILT_LEN (4 with defaults).
  - ym_cs_n goes low one edge later (5).
  - The strobe goes low at 5+SETUP_CYC (6).
  - The strobe goes high at 6+PULSE_CYC (20).
  - ym_cs_n goes high at 20+HOLD_CYC (22).
- Glitches shorter than FILT_LEN synced samples never reach the FSM.
- Command changes during SETUP/STROBE/HOLD are ignored.
- A new command waits in WAIT_REL/IDLE until the previous filter drops.

## Structure
- Package ay_bus_pkg holds:
  - the state enum;
  - the command encoding (NONE/WRADDR/WRDATA/RDDATA);
  - the CTRL_PREFIX constant 5'b11111;
  - the phase counter width function.
- Sub-module ay_sig_filter is instantiated three times. It is parametrised by SYNC_STAGES and FILT_LEN, with an async active-high reset.

## Test plan
- WRADDR then WRDATA to chip 0, with defaults and zd_in=0x27 then 0x15:
  - ym_cs_n[0] is low for 17 cycles per access (1 setup, 14 strobe, 2 hold).
  - ym_wr_n is low for exactly 14 cycles.
  - ym_a0 is 0 then 1; ym_d_out is 0x27 then 0x15.
- Control write 0xFE:
  - chip_sel becomes 1 with no cs/wr activity.
  - A following 0xF0 write shows ym_cs_n=2'b01 (chip 1 selected).
- Control write 0xFA with NCHIPS=2: chip_sel is unchanged and no YM cycle runs.
- RDDATA with ym_d_in=0xA5 during the strobe:
  - ym_rd_n is low for 14 cycles.
  - zd_out=0xA5 after capture.
  - zd_oe tracks the filtered RDDATA.
- A 1-cycle glitch on the controls produces no cycle.
- A command dropping at the 3rd STROBE cycle still completes the full 14-cycle strobe.
- rst asserted mid-STROBE:
  - All outputs return to their reset values within the same cycle.
  - chip_sel=0.
  - The next command runs normally.
